// File: rtl/vliw_wb_writer_if.sv
// Result-slot handshakes and register-file write ports of the writeback writer.
interface vliw_wb_writer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  localparam int unsigned NREG = 1 << ADDR_W;

  logic              res32_valid;
  logic              res32_ready;
  logic [ADDR_W-1:0] res32_rd;
  logic [DATA_W-1:0] res32_data;
  logic              res16_valid;
  logic              res16_ready;
  logic [ADDR_W-1:0] res16_rd;
  logic [DATA_W-1:0] res16_data;
  logic              wb_hold;
  logic              regWrite_32;
  logic [ADDR_W-1:0] rd_32;
  logic [DATA_W-1:0] writeData_32;
  logic              regWrite_16;
  logic [ADDR_W-1:0] rd_16;
  logic [DATA_W-1:0] writeData_16;
  logic [NREG-1:0]   pend_mask;

  // Issue slots / hazard logic side.
  modport master (
    output res32_valid, res32_rd, res32_data,
    output res16_valid, res16_rd, res16_data, wb_hold,
    input  res32_ready, res16_ready,
    input  regWrite_32, rd_32, writeData_32,
    input  regWrite_16, rd_16, writeData_16, pend_mask
  );

  // Writer side.
  modport slave (
    input  res32_valid, res32_rd, res32_data,
    input  res16_valid, res16_rd, res16_data, wb_hold,
    output res32_ready, res16_ready,
    output regWrite_32, rd_32, writeData_32,
    output regWrite_16, rd_16, writeData_16, pend_mask
  );
endinterface

// File: rtl/vliw_wb_writer.sv
// Writeback writer: per-slot result FIFOs feeding the two register-file write
// ports, with program-order resolution of same-destination collisions.
module vliw_wb_writer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SEQ_W  = 4
) (
  input logic           clk,
  input logic           reset,
  vliw_wb_writer_if.slave wb
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam int unsigned HALF  = 1 << (SEQ_W - 1);

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            mem32 [DEPTH];
  entry_t            mem16 [DEPTH];
  logic [PTR_W-1:0]  rdPtr32, wrPtr32, rdPtr16, wrPtr16;
  logic [CNT_W-1:0]  count32, count16;
  logic [SEQ_W-1:0]  seq;
  logic              ready32, ready16, push32, push16, pop32, pop16;
  entry_t            head32, head16;
  logic [SEQ_W-1:0]  ageDiff;
  logic              older32;
  logic              regWrite32Q, regWrite16Q;
  logic [ADDR_W-1:0] rd32Q, rd16Q;
  logic [DATA_W-1:0] data32Q, data16Q;
  logic [NREG-1:0]   pendMask;

  assign ready32 = (count32 < CNT_W'(DEPTH));
  assign ready16 = (count16 < CNT_W'(DEPTH));
  assign push32  = wb.res32_valid && ready32;
  assign push16  = wb.res16_valid && ready16;
  assign head32  = mem32[rdPtr32];
  assign head16  = mem16[rdPtr16];

  // Slot 32 wins ties; otherwise it is older when slot 16's tag is ahead by less than half the tag range.
  assign ageDiff = SEQ_W'(head16.seq - head32.seq);
  assign older32 = (ageDiff < SEQ_W'(HALF));

  // Issue selection: both heads go unless they share a destination.
  always_comb begin
    pop32 = 1'b0;
    pop16 = 1'b0;
    if (!wb.wb_hold) begin
      pop32 = (count32 != '0);
      pop16 = (count16 != '0);
      if (pop32 && pop16 && (head32.rd == head16.rd)) begin
        pop32 = older32;
        pop16 = !older32;
      end
    end
  end

  // FIFO storage writes; contents need no reset since counts gate validity.
  always_ff @(posedge clk) begin
    if (push32) mem32[wrPtr32] <= '{seq: seq, rd: wb.res32_rd, data: wb.res32_data};
    if (push16) mem16[wrPtr16] <= '{seq: seq, rd: wb.res16_rd, data: wb.res16_data};
  end

  // FIFO pointers, counts and age-tag counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr32 <= '0;
      wrPtr32 <= '0;
      count32 <= '0;
      rdPtr16 <= '0;
      wrPtr16 <= '0;
      count16 <= '0;
      seq     <= '0;
    end else begin
      if (push32) wrPtr32 <= wrPtr32 + PTR_W'(1);
      if (pop32)  rdPtr32 <= rdPtr32 + PTR_W'(1);
      if (push16) wrPtr16 <= wrPtr16 + PTR_W'(1);
      if (pop16)  rdPtr16 <= rdPtr16 + PTR_W'(1);
      count32 <= count32 + CNT_W'(push32) - CNT_W'(pop32);
      count16 <= count16 + CNT_W'(push16) - CNT_W'(pop16);
      if (push32 || push16) seq <= seq + SEQ_W'(1);
    end
  end

  // Registered write ports: one-cycle drive per issued entry, zeros when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regWrite32Q <= 1'b0;
      rd32Q       <= '0;
      data32Q     <= '0;
      regWrite16Q <= 1'b0;
      rd16Q       <= '0;
      data16Q     <= '0;
    end else begin
      regWrite32Q <= pop32;
      rd32Q       <= pop32 ? head32.rd : '0;
      data32Q     <= pop32 ? head32.data : '0;
      regWrite16Q <= pop16;
      rd16Q       <= pop16 ? head16.rd : '0;
      data16Q     <= pop16 ? head16.data : '0;
    end
  end

  // Pending mask over every live FIFO entry plus both active ports.
  always_comb begin
    pendMask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count32) pendMask[mem32[PTR_W'(rdPtr32 + PTR_W'(i))].rd] = 1'b1;
      if (CNT_W'(i) < count16) pendMask[mem16[PTR_W'(rdPtr16 + PTR_W'(i))].rd] = 1'b1;
    end
    if (regWrite32Q) pendMask[rd32Q] = 1'b1;
    if (regWrite16Q) pendMask[rd16Q] = 1'b1;
  end

  assign wb.res32_ready  = ready32;
  assign wb.res16_ready  = ready16;
  assign wb.regWrite_32  = regWrite32Q;
  assign wb.rd_32        = rd32Q;
  assign wb.writeData_32 = data32Q;
  assign wb.regWrite_16  = regWrite16Q;
  assign wb.rd_16        = rd16Q;
  assign wb.writeData_16 = data16Q;
  assign wb.pend_mask    = pendMask;
endmodule

// File: tb/tb_vliw_wb_writer.sv
// Bench for vliw_wb_writer: directed scenarios plus random traffic against a queue-based model.
module tb_vliw_wb_writer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vliw_wb_writer_if #(.DATA_W(32), .ADDR_W(5)) wb ();

  vliw_wb_writer #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .SEQ_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          seq;
  } ent_t;

  ent_t        q32[$];
  ent_t        q16[$];
  int          seqM;
  logic [31:0] regFile [32];
  int          nChecks;
  int          nBad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // a is older than b when b is ahead by 1..7 modulo 16.
  function automatic logic older(input int a, input int b);
    int d;
    d = (b - a) & 15;
    return (d >= 1) && (d <= 7);
  endfunction

  // One clock: drive inputs, predict with the model, check the edge's results.
  task automatic step(input logic v32, input logic [4:0] r32, input logic [31:0] d32,
                      input logic v16, input logic [4:0] r16, input logic [31:0] d16,
                      input logic hold);
    logic acc32, acc16, pop32, pop16;
    logic expWe32, expWe16;
    logic [4:0] expRd32, expRd16;
    logic [31:0] expD32, expD16, expMask;
    ent_t e;
    wb.res32_valid = v32; wb.res32_rd = r32; wb.res32_data = d32;
    wb.res16_valid = v16; wb.res16_rd = r16; wb.res16_data = d16;
    wb.wb_hold = hold;
    #1;
    acc32 = (q32.size() < DEPTH);
    acc16 = (q16.size() < DEPTH);
    chk("ready32", wb.res32_ready, acc32);
    chk("ready16", wb.res16_ready, acc16);
    acc32 = acc32 && v32;
    acc16 = acc16 && v16;
    pop32 = !hold && (q32.size() > 0);
    pop16 = !hold && (q16.size() > 0);
    if (pop32 && pop16 && (q32[0].rd == q16[0].rd)) begin
      pop32 = (q32[0].seq == q16[0].seq) || older(q32[0].seq, q16[0].seq);
      pop16 = !pop32;
    end
    expWe32 = pop32; expRd32 = '0; expD32 = '0;
    expWe16 = pop16; expRd16 = '0; expD16 = '0;
    if (pop32) begin expRd32 = q32[0].rd; expD32 = q32[0].data; void'(q32.pop_front()); end
    if (pop16) begin expRd16 = q16[0].rd; expD16 = q16[0].data; void'(q16.pop_front()); end
    if (acc32) begin e.rd = r32; e.data = d32; e.seq = seqM; q32.push_back(e); end
    if (acc16) begin e.rd = r16; e.data = d16; e.seq = seqM; q16.push_back(e); end
    if (acc32 || acc16) seqM = (seqM + 1) % 16;
    @(posedge clk);
    #1;
    chk("regWrite_32", wb.regWrite_32, expWe32);
    chk("rd_32", wb.rd_32, expRd32);
    chk("writeData_32", wb.writeData_32, expD32);
    chk("regWrite_16", wb.regWrite_16, expWe16);
    chk("rd_16", wb.rd_16, expRd16);
    chk("writeData_16", wb.writeData_16, expD16);
    expMask = '0;
    foreach (q32[i]) expMask[q32[i].rd] = 1'b1;
    foreach (q16[i]) expMask[q16[i].rd] = 1'b1;
    if (expWe32) expMask[expRd32] = 1'b1;
    if (expWe16) expMask[expRd16] = 1'b1;
    chk("pend_mask", wb.pend_mask, expMask);
    if (wb.regWrite_32) regFile[wb.rd_32] = wb.writeData_32;
    if (wb.regWrite_16) regFile[wb.rd_16] = wb.writeData_16;
  endtask

  task automatic idle(input logic hold);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, hold);
  endtask

  task automatic checkQuiet(input string tag);
    chk({tag, "_we32"}, wb.regWrite_32, 1'b0);
    chk({tag, "_we16"}, wb.regWrite_16, 1'b0);
    chk({tag, "_data32"}, wb.writeData_32, 32'd0);
    chk({tag, "_pend"}, wb.pend_mask, 32'd0);
    chk({tag, "_rdy32"}, wb.res32_ready, 1'b1);
    chk({tag, "_rdy16"}, wb.res16_ready, 1'b1);
  endtask

  initial begin
    nChecks = 0;
    nBad = 0;
    seqM = 0;
    foreach (regFile[i]) regFile[i] = '0;

    // Reset with offered inputs that must be discarded.
    reset = 1'b1;
    wb.res32_valid = 1'b1; wb.res32_rd = 5'd9; wb.res32_data = 32'h1234;
    wb.res16_valid = 1'b1; wb.res16_rd = 5'd10; wb.res16_data = 32'h5678;
    wb.wb_hold = 1'b0;
    @(posedge clk);
    #1;
    checkQuiet("reset");
    wb.res32_valid = 1'b0;
    wb.res16_valid = 1'b0;
    reset = 1'b0;
    idle(1'b0);
    checkQuiet("after_reset");

    // Single push, one-cycle drive and pending window.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("t2_pend_q", wb.pend_mask[5], 1'b1);
    idle(1'b0);
    chk("t2_we", wb.regWrite_32, 1'b1);
    chk("t2_rd", wb.rd_32, 5'd5);
    chk("t2_data", wb.writeData_32, 32'hDEADBEEF);
    chk("t2_pend_port", wb.pend_mask[5], 1'b1);
    idle(1'b0);
    chk("t2_done_we", wb.regWrite_32, 1'b0);
    chk("t2_done_pend", wb.pend_mask[5], 1'b0);

    // Same-cycle collision on r7: slot 32 first, slot 16 next.
    step(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2, 1'b0);
    idle(1'b0);
    chk("t3_we32", wb.regWrite_32, 1'b1);
    chk("t3_d32", wb.writeData_32, 32'd1);
    chk("t3_we16_first", wb.regWrite_16, 1'b0);
    idle(1'b0);
    chk("t3_we16", wb.regWrite_16, 1'b1);
    chk("t3_d16", wb.writeData_16, 32'd2);
    chk("t3_r7", regFile[7], 32'd2);

    // Hold with five offers: four accepted, fifth waits until space frees.
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(100 + i), 1'b0, 5'd0, 32'd0, 1'b1);
    #1;
    chk("t4_full_ready", wb.res32_ready, 1'b0);
    step(1'b1, 5'd5, 32'd105, 1'b0, 5'd0, 32'd0, 1'b1);
    step(1'b1, 5'd5, 32'd105, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("t4_first_rd", wb.rd_32, 5'd1);
    step(1'b1, 5'd5, 32'd105, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("t4_second_rd", wb.rd_32, 5'd2);
    for (int i = 0; i < 4; i++) idle(1'b0);
    chk("t4_r5", regFile[5], 32'd105);
    chk("t4_r4", regFile[4], 32'd104);

    // Older slot-16 write to r3 beats a younger slot-32 write.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hA, 1'b1);
    step(1'b1, 5'd3, 32'hB, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b0);
    chk("t5_we16", wb.regWrite_16, 1'b1);
    chk("t5_we32_blocked", wb.regWrite_32, 1'b0);
    idle(1'b0);
    chk("t5_we32", wb.regWrite_32, 1'b1);
    chk("t5_r3", regFile[3], 32'hB);

    // Random traffic with small register range to force collisions.
    for (int n = 0; n < 1500; n++) begin
      step(1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 99) < 60), 5'($urandom_range(0, 3)), $urandom,
           1'($urandom_range(0, 99) < 20));
    end
    for (int n = 0; n < 12; n++) idle(1'b0);
    chk("drain_pend", wb.pend_mask, 32'd0);

    // Mid-cycle reset with three queued entries while a port is active.
    step(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12, 1'b1);
    step(1'b1, 5'd13, 32'h13, 1'b0, 5'd0, 32'd0, 1'b1);
    idle(1'b0);
    chk("t6_pre_we", wb.regWrite_32, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    checkQuiet("t6_reset");
    q32.delete();
    q16.delete();
    seqM = 0;
    #2;
    reset = 1'b0;
    for (int n = 0; n < 4; n++) idle(1'b0);
    chk("t6_no_r13", regFile[13], 32'd0);

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
